async_fifo_cdc: RTL
===================

Name: async_fifo_cdc

Overview:
- Parametrised dual-clock FIFO carrying DATA_W-bit words from the write_clk domain to the read_clk domain.
- Uses Gray-coded pointers, each crossing through a 2-flop synchroniser. Full and empty are computed locally in each domain, so each flag depends only on its own clock.
- Adds a registered read port with a valid strobe, domain-local fill levels, almost-full/almost-empty thresholds and overflow/underflow error pulses.
- Used at every clock-domain boundary in the SoC datapath.

Parameters:
- DATA_W, 8, word width in bits (>=1)
- ADDR_W, 3, log2 of depth; DEPTH = 2**ADDR_W words (ADDR_W >= 2)
- SYNC_STAGES, 2, synchroniser flops per pointer crossing (>=2)
- AFULL_TH, 6, wr_almost_full asserts when wr_level >= AFULL_TH
- AEMPTY_TH, 2, rd_almost_empty asserts when rd_level <= AEMPTY_TH

Ports:
- reset  input  1  asynchronous, active-low; clears both domains
- write_clk  input  1  write-domain clock
- read_clk  input  1  read-domain clock
- wr_en  input  1  write request, write_clk domain
- wr_data  input  DATA_W  write data
- wr_full  output  1  no free entry (write domain)
- wr_almost_full  output  1  level threshold flag
- wr_level  output  ADDR_W+1  write-side occupancy, conservative
- wr_overflow  output  1  one-cycle pulse: wr_en while wr_full
- rd_en  input  1  read request, read_clk domain
- rd_data  output  DATA_W  registered read data
- rd_valid  output  1  rd_data holds a new word this cycle
- rd_empty  output  1  no readable entry (read domain)
- rd_almost_empty  output  1  level threshold flag
- rd_level  output  ADDR_W+1  read-side occupancy, conservative
- rd_underflow  output  1  one-cycle pulse: rd_en while rd_empty

Behaviour:
- Pointers:
  - wr_bin and rd_bin are ADDR_W+1 bits wide and wrap modulo 2**(ADDR_W+1).
  - Gray code is gray = bin ^ (bin >> 1), registered in the source domain before the crossing. No combinational logic sits between the Gray register and the first sync flop.
- Write:
  - When wr_en && !wr_full at a write_clk edge, store mem[wr_bin[ADDR_W-1:0]] <= wr_data and increment wr_bin.
  - When wr_en && wr_full, drop the write, leave wr_bin unchanged and assert wr_overflow for one cycle.
- Read:
  - When rd_en && !rd_empty at a read_clk edge, rd_data <= mem[rd_bin[ADDR_W-1:0]], rd_valid <= 1 and rd_bin increments. Latency is 1 cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its value.
  - When rd_en && rd_empty, assert rd_underflow for one cycle.
- Full (registered, from the next-state pointer): wr_gray_next == {~rd_gray_sync[ADDR_W:ADDR_W-1], rd_gray_sync[ADDR_W-2:0]}.
- Empty (registered, from the next-state pointer): rd_gray_next == wr_gray_sync.
- Levels:
  - wr_level = wr_bin - gray2bin(rd_gray_sync)
  - rd_level = gray2bin(wr_gray_sync) - rd_bin
  - Both are computed modulo 2**(ADDR_W+1), giving a range of 0..DEPTH. They are pessimistic: wr_level may over-report and rd_level may under-report, never the reverse.
- Crossing latency:
  - A committed write clears rd_empty after SYNC_STAGES+1 read_clk edges.
  - A committed read clears wr_full after SYNC_STAGES+1 write_clk edges.
  - Flags never assert falsely toward unsafe: data is never lost or duplicated.
- Simultaneous read and write: always legal. Levels converge once the pointers settle.
- Wrap-around: exactly DEPTH writes with no reads sets wr_full. The MSB difference distinguishes full from empty.
- Reset:
  - Asynchronous assert and synchronous deassert in each domain, via a local 2-flop reset synchroniser per domain.
  - Reset values: wr_bin/rd_bin/Gray/sync flops = 0, wr_full=0, wr_almost_full=(AFULL_TH==0), wr_level=0, wr_overflow=0, rd_empty=1, rd_valid=0, rd_data=0, rd_level=0, rd_almost_empty=1, rd_underflow=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all contents, and both sides resume from the empty state.
- Each output is driven from exactly one always_ff. There are no multi-clock processes and no shared counters.

Decomposition:
- Package fifo_pkg holds:
  - bin2gray and gray2bin functions, parametrised by width;
  - a localparam for the default SYNC_STAGES.
- Sub-module cdc_sync_bus: a SYNC_STAGES-deep flop chain for a WIDTH-bit Gray bus, with asynchronous active-low reset. It is instantiated twice, once for wr->rd and once for rd->wr.
- The memory is an inferred register array inside the top level. It is written on write_clk and read on read_clk.

Test Plan:
- Reset, then write 8 words 0x01..0x08 with read_clk idle -> wr_full=1 after the 8th write and wr_level=8. A 9th write asserts wr_overflow for 1 cycle and leaves the contents unchanged.
- Read all words after full -> rd_data sequence 0x01..0x08 with rd_valid on each. rd_empty=1 after the 8th read; a further rd_en asserts rd_underflow.
- write_clk 100 MHz, read_clk 37 MHz, random wr_en/rd_en, 10k words -> scoreboard shows exact in-order data, no overflow/underflow when the flags are honoured, and wr_level never below the true occupancy.
- Single write into an empty FIFO -> rd_empty falls exactly SYNC_STAGES+1 (=3) read_clk edges later.
- Pointer wrap: 3*DEPTH+3 words streamed at equal clocks -> no false full/empty, and the data matches.
- Assert reset with 5 words stored, mid-burst -> all outputs hold their reset values. The next write/read pair returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and default CDC depth.
// The conversions take a wide word; callers zero-extend narrower pointers and truncate the result.
package fifo_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int GRAY_MAX_W          = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    function automatic gray_word_t bin2gray(input gray_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it. Leading zeros do not change it.
    function automatic gray_word_t gray2bin(input gray_word_t gray);
        gray_word_t bin;
        bin = gray;
        for (int i = 1; i < GRAY_MAX_W; i++) begin
            bin = bin ^ (gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser for a Gray-coded bus. Only one bit changes per source update,
// so every sampled value is either the old pointer or the new one.
module cdc_sync_bus #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= data_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_cdc.sv
// Dual-clock FIFO with Gray-pointer crossings, registered read port, domain-local
// levels, threshold flags and overflow/underflow pulses.
module async_fifo_cdc
    import fifo_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int AFULL_TH    = 6,
    parameter int AEMPTY_TH   = 2
) (
    input  logic              reset,
    input  logic              write_clk,
    input  logic              read_clk,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    output logic              wr_almost_full,
    output logic [ADDR_W:0]   wr_level,
    output logic              wr_overflow,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_empty,
    output logic              rd_almost_empty,
    output logic [ADDR_W:0]   rd_level,
    output logic              rd_underflow
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;

    localparam ptr_t AFULL_LV  = ptr_t'(AFULL_TH);
    localparam ptr_t AEMPTY_LV = ptr_t'(AEMPTY_TH);
    localparam logic AFULL_RST = (AFULL_TH == 0);

    logic [DATA_W-1:0] mem [DEPTH];

    // ---------------- write domain ----------------
    logic [1:0] wr_rst_q;
    logic       wr_rst_n;

    // NOTE: reset asserts asynchronously but releases on a clock edge, so no flop sees a runt recovery.
    always_ff @(posedge write_clk or negedge reset) begin
        if (!reset) wr_rst_q <= '0;
        else        wr_rst_q <= {wr_rst_q[0], 1'b1};
    end
    assign wr_rst_n = wr_rst_q[1];

    ptr_t wr_bin_q, wr_gray_q, wr_level_q;
    ptr_t wr_bin_d, wr_gray_d, wr_level_d;
    ptr_t rd_gray_sync, rd_bin_sync;
    logic wr_full_q, wr_full_d, wr_afull_q, wr_overflow_q, wr_push;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        wr_push     = wr_en && !wr_full_q;
        wr_bin_d    = wr_bin_q + ptr_t'(wr_push);
        wr_gray_d   = ptr_t'(bin2gray(gray_word_t'(wr_bin_d)));
        rd_bin_sync = ptr_t'(gray2bin(gray_word_t'(rd_gray_sync)));
        wr_level_d  = wr_bin_d - rd_bin_sync;
        wr_full_d   = (wr_gray_d == {~rd_gray_sync[ADDR_W -: 2], rd_gray_sync[ADDR_W-2:0]});
    end

    always_ff @(posedge write_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            wr_bin_q      <= '0;
            wr_gray_q     <= '0;
            wr_full_q     <= 1'b0;
            wr_level_q    <= '0;
            wr_afull_q    <= AFULL_RST;
            wr_overflow_q <= 1'b0;
        end else begin
            wr_bin_q      <= wr_bin_d;
            wr_gray_q     <= wr_gray_d;
            wr_full_q     <= wr_full_d;
            wr_level_q    <= wr_level_d;
            wr_afull_q    <= (wr_level_d >= AFULL_LV);
            wr_overflow_q <= wr_en && wr_full_q;
        end
    end

    // NOTE: the storage array has no reset; pointers alone define which entries are live.
    always_ff @(posedge write_clk) begin
        if (wr_push) mem[wr_bin_q[ADDR_W-1:0]] <= wr_data;
    end

    assign wr_full        = wr_full_q;
    assign wr_almost_full = wr_afull_q;
    assign wr_level       = wr_level_q;
    assign wr_overflow    = wr_overflow_q;

    // ---------------- read domain ----------------
    logic [1:0] rd_rst_q;
    logic       rd_rst_n;

    always_ff @(posedge read_clk or negedge reset) begin
        if (!reset) rd_rst_q <= '0;
        else        rd_rst_q <= {rd_rst_q[0], 1'b1};
    end
    assign rd_rst_n = rd_rst_q[1];

    ptr_t rd_bin_q, rd_gray_q, rd_level_q;
    ptr_t rd_bin_d, rd_gray_d, rd_level_d;
    ptr_t wr_gray_sync, wr_bin_sync;
    logic rd_empty_q, rd_empty_d, rd_aempty_q, rd_valid_q, rd_underflow_q, rd_pop;
    logic [DATA_W-1:0] rd_data_q;

    always_comb begin
        rd_pop      = rd_en && !rd_empty_q;
        rd_bin_d    = rd_bin_q + ptr_t'(rd_pop);
        rd_gray_d   = ptr_t'(bin2gray(gray_word_t'(rd_bin_d)));
        wr_bin_sync = ptr_t'(gray2bin(gray_word_t'(wr_gray_sync)));
        rd_level_d  = wr_bin_sync - rd_bin_d;
        rd_empty_d  = (rd_gray_d == wr_gray_sync);
    end

    always_ff @(posedge read_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            rd_bin_q       <= '0;
            rd_gray_q      <= '0;
            rd_empty_q     <= 1'b1;
            rd_level_q     <= '0;
            rd_aempty_q    <= 1'b1;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_underflow_q <= 1'b0;
        end else begin
            rd_bin_q       <= rd_bin_d;
            rd_gray_q      <= rd_gray_d;
            rd_empty_q     <= rd_empty_d;
            rd_level_q     <= rd_level_d;
            rd_aempty_q    <= (rd_level_d <= AEMPTY_LV);
            rd_valid_q     <= rd_pop;
            rd_underflow_q <= rd_en && rd_empty_q;
            if (rd_pop) rd_data_q <= mem[rd_bin_q[ADDR_W-1:0]];
        end
    end

    assign rd_data         = rd_data_q;
    assign rd_valid        = rd_valid_q;
    assign rd_empty        = rd_empty_q;
    assign rd_almost_empty = rd_aempty_q;
    assign rd_level        = rd_level_q;
    assign rd_underflow    = rd_underflow_q;

    // ---------------- pointer crossings ----------------
    cdc_sync_bus #(.WIDTH(ADDR_W + 1), .STAGES(SYNC_STAGES)) u_sync_w2r (
        .clk_i   (read_clk),
        .rst_n_i (rd_rst_n),
        .data_i  (wr_gray_q),
        .data_o  (wr_gray_sync)
    );

    cdc_sync_bus #(.WIDTH(ADDR_W + 1), .STAGES(SYNC_STAGES)) u_sync_r2w (
        .clk_i   (write_clk),
        .rst_n_i (wr_rst_n),
        .data_i  (rd_gray_q),
        .data_o  (rd_gray_sync)
    );

endmodule
